fpadd_arbiter: RTL and testbench

Shares one multi-cycle single-precision FP adder between NUM_REQ requesters. It arbitrates round-robin, latches the winner's operands and pulses the adder start. It then waits for the adder's done pulse, with a watchdog timeout, and returns the tagged result on one shared response channel. It sits between the client blocks and the fpadder instance and is the only block that drives the adder inputs.

---
 rtl/fpadd_arbiter.sv | 176 +++++++++++++++++
 tb/tb_fpadd_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpadd_arbiter.sv
// fpadd_arbiter: round-robin front end that shares one multi-cycle FP adder
// between NUM_REQ clients. One operation is in flight at a time. A watchdog
// abandons an operation whose done pulse never arrives.
module fpadd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_op1,
  input  logic [32*NUM_REQ-1:0]  req_op2,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [31:0]            resp_result,
  output logic                   resp_timeout,
  output logic [31:0]            adder_op1,
  output logic [31:0]            adder_op2,
  output logic                   adder_start,
  output logic                   adder_flush,
  input  logic                   adder_done,
  input  logic [31:0]            adder_result
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]         r_state;
  logic [ID_W-1:0]    r_last_grant;
  logic [ID_W-1:0]    r_id;
  logic [31:0]        r_op1;
  logic [31:0]        r_op2;
  logic [31:0]        r_result;
  logic               r_timeout;
  logic               r_resp_valid;
  logic               r_start;
  logic               r_flush;
  logic [CNT_W-1:0]   r_wait_cnt;

  logic               w_found;
  logic [ID_W-1:0]    w_gnt_idx;
  logic [NUM_REQ-1:0] w_ready;
  logic [31:0]        w_op1;
  logic [31:0]        w_op2;
  logic               w_wait_expired;

  // Round-robin search: first valid requester after last_grant, wrapping.
  always_comb begin
    logic [ID_W:0] v_sum;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    v_sum     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      v_sum = {1'b0, r_last_grant} + (ID_W+1)'(k);
      if (v_sum >= (ID_W+1)'(NUM_REQ)) begin
        v_sum = v_sum - (ID_W+1)'(NUM_REQ);
      end else begin
        v_sum = v_sum;
      end
      if (!w_found && req_valid[v_sum[ID_W-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = v_sum[ID_W-1:0];
      end else begin
        w_found   = w_found;
      end
    end
  end

  // Accept strobe is combinational so the grant lands on the same edge.
  always_comb begin
    w_ready = '0;
    if ((r_state == S_IDLE) && w_found) begin
      w_ready[w_gnt_idx] = 1'b1;
    end else begin
      w_ready = '0;
    end
  end

  // Winner's operand slice out of the packed operand buses.
  always_comb begin
    w_op1 = req_op1[{w_gnt_idx, 5'd0} +: 32];
    w_op2 = req_op2[{w_gnt_idx, 5'd0} +: 32];
  end

  // Watchdog fires on the last of TIMEOUT cycles spent in WAIT.
  always_comb begin
    w_wait_expired = (r_wait_cnt == CNT_W'(TIMEOUT - 1));
  end

  // Main control FSM with operand, response and pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_id         <= '0;
      r_op1        <= 32'd0;
      r_op2        <= 32'd0;
      r_result     <= 32'd0;
      r_timeout    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_start      <= 1'b0;
      r_flush      <= 1'b0;
      r_wait_cnt   <= '0;
    end else begin
      // start and flush are single-cycle pulses unless re-armed below
      r_start <= 1'b0;
      r_flush <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_op1   <= w_op1;
            r_op2   <= w_op2;
            r_id    <= w_gnt_idx;
            r_start <= 1'b1;
            r_state <= S_ISSUE;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          // a done pulse here belongs to nothing we issued; ignore it
          r_wait_cnt <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          if (adder_done) begin
            // done beats a simultaneous watchdog expiry
            r_result     <= adder_result;
            r_timeout    <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end else if (w_wait_expired) begin
            r_result     <= 32'd0;
            r_timeout    <= 1'b1;
            r_flush      <= 1'b1;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_last_grant <= r_id;
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_state <= S_RESP;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready    = w_ready;
  assign resp_valid   = r_resp_valid;
  assign resp_id      = r_id;
  assign resp_result  = r_result;
  assign resp_timeout = r_timeout;
  assign adder_op1    = r_op1;
  assign adder_op2    = r_op2;
  assign adder_start  = r_start;
  assign adder_flush  = r_flush;

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Directed bench for fpadd_arbiter with a behavioural multi-cycle adder.
module tb_fpadd_arbiter;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_op1;
  logic [127:0] req_op2;
  logic         resp_valid;
  logic         resp_ready;
  logic [1:0]   resp_id;
  logic [31:0]  resp_result;
  logic         resp_timeout;
  logic [31:0]  adder_op1;
  logic [31:0]  adder_op2;
  logic         adder_start;
  logic         adder_flush;
  logic         adder_done;
  logic [31:0]  adder_result;

  fpadd_arbiter #(.NUM_REQ(4), .ID_W(2), .TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result), .resp_timeout(resp_timeout),
    .adder_op1(adder_op1), .adder_op2(adder_op2),
    .adder_start(adder_start), .adder_flush(adder_flush),
    .adder_done(adder_done), .adder_result(adder_result)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Operands per requester and their hand-computed single-precision sums.
  logic [31:0] op1_tab [4] = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h3F000000};
  logic [31:0] op2_tab [4] = '{32'h40000000, 32'h40000000, 32'h3F800000, 32'h3F000000};
  logic [31:0] sum_tab [4] = '{32'h40400000, 32'h40800000, 32'h40000000, 32'h3F800000};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_sum(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      if (a == op1_tab[i] && b == op2_tab[i]) r = sum_tab[i];
    end
    return r;
  endfunction

  // Adder model: done model_delay cycles after start; 0 means never.
  int          model_delay = 3;
  int          m_cnt = -1;
  bit          m_stray = 1'b0;
  logic [31:0] m_op1, m_op2;
  initial begin
    adder_done   = 1'b0;
    adder_result = 32'd0;
    forever begin
      @(negedge clk);
      adder_done   = 1'b0;
      adder_result = 32'd0;
      if (m_stray) begin
        adder_done   = 1'b1;
        adder_result = 32'h12345678;
        m_stray      = 1'b0;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          adder_done   = 1'b1;
          adder_result = model_sum(m_op1, m_op2);
          m_cnt        = -1;
        end
      end
      if (adder_start && model_delay > 0) begin
        m_cnt = model_delay;
        m_op1 = adder_op1;
        m_op2 = adder_op2;
      end
    end
  end

  // Monitors: grants, start/flush pulses and completed responses.
  logic [3:0]  gnt_q[$];
  logic [1:0]  rid_q[$];
  logic [31:0] rres_q[$];
  int          n_start = 0;
  int          n_flush = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (req_ready != 4'd0) gnt_q.push_back(req_ready);
      if (adder_start) n_start++;
      if (adder_flush) n_flush++;
      if (resp_valid && resp_ready) begin
        rid_q.push_back(resp_id);
        rres_q.push_back(resp_result);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 100);
    check_eq("resp_seen", 32'(resp_valid), 32'd1);
  endtask

  // Request with vector v, expect grant g, then wait for the response.
  task automatic do_req(input logic [3:0] v, input logic [3:0] g, output int n);
    int k;
    tick();
    req_valid = v;
    @(negedge clk);
    k = 0;
    while (req_ready == 4'd0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("grant", 32'(req_ready), 32'(g));
    tick();
    req_valid = 4'd0;
    @(negedge clk);
    check_eq("start", 32'(adder_start), 32'd1);
    wait_resp(n);
  endtask

  task automatic pulse_reset();
    tick();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    int hi;
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    int hi;
    reset_n    = 1'b0;
    req_valid  = 4'd0;
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_op1[32*i +: 32] = op1_tab[i];
      req_op2[32*i +: 32] = op2_tab[i];
    end
    tick(); tick();
    @(negedge clk);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_start", 32'(adder_start), 32'd0);
    check_eq("rst_flush", 32'(adder_flush), 32'd0);
    check_eq("rst_op1", adder_op1, 32'd0);
    check_eq("rst_result", resp_result, 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    tick();
    reset_n = 1'b1;

    // 1: single request, done 3 cycles after start
    resp_ready  = 1'b1;
    model_delay = 3;
    n_start     = 0;
    gnt_q.delete();
    do_req(4'b0001, 4'b0001, n);
    check_eq("t1_latency", 32'(n), 32'd4);
    check_eq("t1_id", 32'(resp_id), 32'd0);
    check_eq("t1_result", resp_result, 32'h40400000);
    check_eq("t1_timeout", 32'(resp_timeout), 32'd0);
    check_eq("t1_op1", adder_op1, 32'h3F800000);
    check_eq("t1_op2", adder_op2, 32'h40000000);
    @(negedge clk);
    check_eq("t1_valid_fall", 32'(resp_valid), 32'd0);
    check_eq("t1_nstart", 32'(n_start), 32'd1);
    check_eq("t1_ngrant", 32'(gnt_q.size()), 32'd1);

    // 2: all four continuously, round robin from 0 after reset
    pulse_reset();
    model_delay = 2;
    n_start = 0;
    gnt_q.delete(); rid_q.delete(); rres_q.delete();
    req_valid = 4'b1111;
    n = 0;
    while (rid_q.size() < 8 && n < 300) begin
      @(negedge clk);
      n++;
    end
    tick();
    req_valid = 4'd0;
    check_eq("t2_nresp", 32'(rid_q.size()), 32'd8);
    check_eq("t2_ngrant", 32'(gnt_q.size()), 32'd8);
    check_eq("t2_nstart", 32'(n_start), 32'd8);
    for (int i = 0; i < 8 && i < rid_q.size() && i < gnt_q.size(); i++) begin
      check_eq("t2_grant", 32'(gnt_q[i]), 32'(4'b0001 << (i % 4)));
      check_eq("t2_id", 32'(rid_q[i]), 32'(i % 4));
      check_eq("t2_result", rres_q[i], sum_tab[i % 4]);
    end

    // 3: after grant to 2, requesters 1 and 3 -> 3, 1, 3
    gnt_q.delete(); rid_q.delete(); rres_q.delete();
    tick();
    req_valid = 4'b0100;
    n = 0;
    while (gnt_q.size() < 1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tick();
    req_valid = 4'b1010;
    n = 0;
    while (rid_q.size() < 4 && n < 300) begin
      @(negedge clk);
      n++;
    end
    tick();
    req_valid = 4'd0;
    check_eq("t3_nresp", 32'(rid_q.size()), 32'd4);
    if (rid_q.size() >= 4 && gnt_q.size() >= 4) begin
      check_eq("t3_g0", 32'(gnt_q[0]), 32'b0100);
      check_eq("t3_g1", 32'(gnt_q[1]), 32'b1000);
      check_eq("t3_g2", 32'(gnt_q[2]), 32'b0010);
      check_eq("t3_g3", 32'(gnt_q[3]), 32'b1000);
      check_eq("t3_id1", 32'(rid_q[1]), 32'd3);
      check_eq("t3_id2", 32'(rid_q[2]), 32'd1);
      check_eq("t3_res2", rres_q[2], 32'h40800000);
    end

    // 4: adder never completes -> watchdog after 8 WAIT cycles
    model_delay = 0;
    n_flush = 0;
    do_req(4'b0010, 4'b0010, n);
    check_eq("t4_latency", 32'(n), 32'd9);
    check_eq("t4_flush", 32'(adder_flush), 32'd1);
    check_eq("t4_timeout", 32'(resp_timeout), 32'd1);
    check_eq("t4_result", resp_result, 32'd0);
    check_eq("t4_id", 32'(resp_id), 32'd1);
    @(negedge clk);
    check_eq("t4_flush_fall", 32'(adder_flush), 32'd0);
    check_eq("t4_nflush", 32'(n_flush), 32'd1);
    model_delay = 2;
    do_req(4'b0100, 4'b0100, n);
    check_eq("t4b_result", resp_result, 32'h40000000);
    check_eq("t4b_timeout", 32'(resp_timeout), 32'd0);

    // 5: done coincident with expiry, response held for 5 cycles
    tick();
    resp_ready  = 1'b0;
    model_delay = 8;
    n_flush     = 0;
    do_req(4'b1000, 4'b1000, n);
    check_eq("t5_latency", 32'(n), 32'd9);
    check_eq("t5_flush", 32'(adder_flush), 32'd0);
    check_eq("t5_timeout", 32'(resp_timeout), 32'd0);
    check_eq("t5_result", resp_result, 32'h3F800000);
    for (int c = 0; c < 4; c++) begin
      tick();
      req_valid = 4'b1111;
      @(negedge clk);
      check_eq("t5_hold_valid", 32'(resp_valid), 32'd1);
      check_eq("t5_hold_id", 32'(resp_id), 32'd3);
      check_eq("t5_hold_result", resp_result, 32'h3F800000);
      check_eq("t5_hold_ready", 32'(req_ready), 32'd0);
    end
    tick();
    resp_ready  = 1'b1;
    model_delay = 2;
    @(negedge clk);
    check_eq("t5_hs_ready", 32'(req_ready), 32'd0);
    check_eq("t5_hs_valid", 32'(resp_valid), 32'd1);
    tick();
    @(negedge clk);
    check_eq("t5_next_grant", 32'(req_ready), 32'b0001);
    check_eq("t5_valid_fall", 32'(resp_valid), 32'd0);
    tick();
    req_valid = 4'd0;
    wait_resp(n);
    check_eq("t5b_id", 32'(resp_id), 32'd0);
    check_eq("t5b_result", resp_result, 32'h40400000);
    check_eq("t5_nflush", 32'(n_flush), 32'd0);

    // 6: reset during WAIT drops the operation
    model_delay = 5;
    tick();
    req_valid = 4'b0100;
    @(negedge clk);
    check_eq("t6_grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'd0;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", 32'(resp_valid), 32'd0);
    check_eq("t6_rst_op1", adder_op1, 32'd0);
    check_eq("t6_rst_op2", adder_op2, 32'd0);
    check_eq("t6_rst_start", 32'(adder_start), 32'd0);
    check_eq("t6_rst_id", 32'(resp_id), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    m_stray = 1'b1;
    hi = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (resp_valid) hi++;
    end
    check_eq("t6_no_resp", 32'(hi), 32'd0);
    model_delay = 2;
    tick();
    req_valid = 4'b1111;
    @(negedge clk);
    check_eq("t6_first_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'd0;
    wait_resp(n);
    check_eq("t6_id", 32'(resp_id), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
